// File: rtl/bsg_dmi_axil_master.sv
// bsg_dmi_axil_master
// Converts one RISC-V DMI request at a time into a single AXI-lite master
// transaction on the debug module's DMI window. It returns a DMI response that
// carries read data and a 2-bit status (0 ok, 2 failed). A cycle timer recovers
// from a slave that never answers. Once that happens, any response the slave
// sends later is drained in the ORPHAN state before new requests are accepted.
// axil_data_width_p must be 32, and base_addr_p plus the 512-byte DMI window
// must stay below 32'h130000.
module bsg_dmi_axil_master #(
  parameter int                           dmi_addr_width_p  = 7,
  parameter int                           axil_addr_width_p = 32,
  parameter int                           axil_data_width_p = 32,
  parameter logic [axil_addr_width_p-1:0] base_addr_p       = '0,
  parameter int                           timeout_p         = 1024
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,

  input  logic                           dmi_req_valid_i,
  output logic                           dmi_req_ready_o,
  input  logic [dmi_addr_width_p-1:0]    dmi_req_addr_i,
  input  logic [1:0]                     dmi_req_op_i,
  input  logic [axil_data_width_p-1:0]   dmi_req_data_i,

  output logic                           dmi_resp_valid_o,
  input  logic                           dmi_resp_ready_i,
  output logic [axil_data_width_p-1:0]   dmi_resp_data_o,
  output logic [1:0]                     dmi_resp_resp_o,

  output logic [axil_addr_width_p-1:0]   m_axil_awaddr,
  output logic [2:0]                     m_axil_awprot,
  output logic                           m_axil_awvalid,
  input  logic                           m_axil_awready,
  output logic [axil_data_width_p-1:0]   m_axil_wdata,
  output logic [axil_data_width_p/8-1:0] m_axil_wstrb,
  output logic                           m_axil_wvalid,
  input  logic                           m_axil_wready,
  input  logic [1:0]                     m_axil_bresp,
  input  logic                           m_axil_bvalid,
  output logic                           m_axil_bready,
  output logic [axil_addr_width_p-1:0]   m_axil_araddr,
  output logic [2:0]                     m_axil_arprot,
  output logic                           m_axil_arvalid,
  input  logic                           m_axil_arready,
  input  logic [axil_data_width_p-1:0]   m_axil_rdata,
  input  logic [1:0]                     m_axil_rresp,
  input  logic                           m_axil_rvalid,
  output logic                           m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE, WR, WB, RD, RR, RESP, ORPHAN
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0, OP_READ = 2'd1, OP_WRITE = 2'd2, OP_RSVD = 2'd3
  } dmi_op_e;

  localparam logic [1:0] resp_ok_lp   = 2'd0;
  localparam logic [1:0] resp_fail_lp = 2'd2;
  localparam int timer_width_lp = (timeout_p > 0) ? $clog2(timeout_p + 1) : 1;

  state_e                         state_r;
  logic [axil_addr_width_p-1:0]   addr_r;
  logic [axil_data_width_p-1:0]   wdata_r;
  logic [timer_width_lp-1:0]      timer_r;
  logic                           aw_done_r, w_done_r;
  logic                           pending_orphan_r;

  logic aw_done_next, w_done_next;
  logic b_fire, r_fire, timeout_hit;

  // Write completes when both channels have handshaken, in either order or together.
  assign aw_done_next = aw_done_r | (m_axil_awvalid & m_axil_awready);
  assign w_done_next  = w_done_r  | (m_axil_wvalid  & m_axil_wready);
  assign b_fire       = m_axil_bvalid & m_axil_bready;
  assign r_fire       = m_axil_rvalid & m_axil_rready;
  assign timeout_hit  = (timeout_p != 0) && (timer_r == timer_width_lp'(timeout_p));

  // Constant channel fields and address/data registers shared by both directions.
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;
  assign m_axil_wstrb  = '1;
  assign m_axil_awaddr = addr_r;
  assign m_axil_araddr = addr_r;
  assign m_axil_wdata  = wdata_r;

  // Transaction FSM. Every handshake and response output is a register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r          <= IDLE;
      addr_r           <= '0;
      wdata_r          <= '0;
      timer_r          <= '0;
      aw_done_r        <= 1'b0;
      w_done_r         <= 1'b0;
      pending_orphan_r <= 1'b0;
      dmi_req_ready_o  <= 1'b0;
      dmi_resp_valid_o <= 1'b0;
      dmi_resp_data_o  <= '0;
      dmi_resp_resp_o  <= resp_ok_lp;
      m_axil_awvalid   <= 1'b0;
      m_axil_wvalid    <= 1'b0;
      m_axil_bready    <= 1'b0;
      m_axil_arvalid   <= 1'b0;
      m_axil_rready    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of the state registers no matter what order they are written in.
      case (state_r)
        IDLE: begin
          dmi_req_ready_o <= 1'b1;
          if (dmi_req_valid_i && dmi_req_ready_o) begin
            dmi_req_ready_o <= 1'b0;
            addr_r  <= base_addr_p + axil_addr_width_p'({dmi_req_addr_i, 2'b00});
            wdata_r <= dmi_req_data_i;
            timer_r <= '0;
            case (dmi_op_e'(dmi_req_op_i))
              OP_READ: begin
                m_axil_arvalid <= 1'b1;
                state_r        <= RD;
              end
              OP_WRITE: begin
                m_axil_awvalid <= 1'b1;
                m_axil_wvalid  <= 1'b1;
                aw_done_r      <= 1'b0;
                w_done_r       <= 1'b0;
                state_r        <= WR;
              end
              OP_NOP: begin
                dmi_resp_valid_o <= 1'b1;
                dmi_resp_data_o  <= '0;
                dmi_resp_resp_o  <= resp_ok_lp;
                state_r          <= RESP;
              end
              default: begin
                dmi_resp_valid_o <= 1'b1;
                dmi_resp_data_o  <= '0;
                dmi_resp_resp_o  <= resp_fail_lp;
                state_r          <= RESP;
              end
            endcase
          end
        end

        WR: begin
          timer_r <= timer_r + 1'b1;
          if (timeout_hit) begin
            // Withdrawing valids breaks AXI hold rules; only done for a hung slave.
            m_axil_awvalid   <= 1'b0;
            m_axil_wvalid    <= 1'b0;
            dmi_resp_valid_o <= 1'b1;
            dmi_resp_data_o  <= '0;
            dmi_resp_resp_o  <= resp_fail_lp;
            pending_orphan_r <= 1'b1;
            state_r          <= RESP;
          end else begin
            if (m_axil_awvalid && m_axil_awready) begin
              m_axil_awvalid <= 1'b0;
              aw_done_r      <= 1'b1;
            end
            if (m_axil_wvalid && m_axil_wready) begin
              m_axil_wvalid <= 1'b0;
              w_done_r      <= 1'b1;
            end
            if (aw_done_next && w_done_next) begin
              m_axil_bready <= 1'b1;
              state_r       <= WB;
            end
          end
        end

        WB: begin
          timer_r <= timer_r + 1'b1;
          if (b_fire) begin
            m_axil_bready    <= 1'b0;
            dmi_resp_valid_o <= 1'b1;
            dmi_resp_data_o  <= '0;
            dmi_resp_resp_o  <= (m_axil_bresp != 2'b00) ? resp_fail_lp : resp_ok_lp;
            state_r          <= RESP;
          end else if (timeout_hit) begin
            m_axil_bready    <= 1'b0;
            dmi_resp_valid_o <= 1'b1;
            dmi_resp_data_o  <= '0;
            dmi_resp_resp_o  <= resp_fail_lp;
            pending_orphan_r <= 1'b1;
            state_r          <= RESP;
          end
        end

        RD: begin
          timer_r <= timer_r + 1'b1;
          if (timeout_hit) begin
            m_axil_arvalid   <= 1'b0;
            dmi_resp_valid_o <= 1'b1;
            dmi_resp_data_o  <= '0;
            dmi_resp_resp_o  <= resp_fail_lp;
            pending_orphan_r <= 1'b1;
            state_r          <= RESP;
          end else if (m_axil_arvalid && m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state_r        <= RR;
          end
        end

        RR: begin
          timer_r <= timer_r + 1'b1;
          if (r_fire) begin
            m_axil_rready    <= 1'b0;
            dmi_resp_valid_o <= 1'b1;
            if (m_axil_rresp != 2'b00) begin
              dmi_resp_data_o <= '0;
              dmi_resp_resp_o <= resp_fail_lp;
            end else begin
              dmi_resp_data_o <= m_axil_rdata;
              dmi_resp_resp_o <= resp_ok_lp;
            end
            state_r <= RESP;
          end else if (timeout_hit) begin
            m_axil_rready    <= 1'b0;
            dmi_resp_valid_o <= 1'b1;
            dmi_resp_data_o  <= '0;
            dmi_resp_resp_o  <= resp_fail_lp;
            pending_orphan_r <= 1'b1;
            state_r          <= RESP;
          end
        end

        RESP: begin
          if (dmi_resp_valid_o && dmi_resp_ready_i) begin
            dmi_resp_valid_o <= 1'b0;
            if (pending_orphan_r) begin
              m_axil_bready <= 1'b1;
              m_axil_rready <= 1'b1;
              state_r       <= ORPHAN;
            end else begin
              dmi_req_ready_o <= 1'b1;
              state_r         <= IDLE;
            end
          end
        end

        ORPHAN: begin
          // Absorb whatever late response the hung slave eventually produces.
          if (b_fire || r_fire) begin
            m_axil_bready    <= 1'b0;
            m_axil_rready    <= 1'b0;
            pending_orphan_r <= 1'b0;
            dmi_req_ready_o  <= 1'b1;
            state_r          <= IDLE;
          end
        end

        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_dmi_axil_master.sv
// Directed bench for bsg_dmi_axil_master. A reactive AXI-lite slave with
// per-channel latencies answers the DUT. Each task drives a single scenario and
// compares the DUT outputs against hand-computed values.
module tb_bsg_dmi_axil_master;

  localparam logic [31:0] base_lp    = 32'h0000_0100;
  localparam int          timeout_lp = 8;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [6:0]  req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Slave configuration and observation
  int          aw_lat, w_lat, ar_lat, b_lat, r_lat;
  bit          b_never, r_never;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] rdata_cfg;
  int          aw_hs, w_hs, b_hs, ar_hs, r_hs, valid_seen;
  logic [31:0] awaddr_cap, wdata_cap, araddr_cap;
  bit          aw_got, w_got, ar_got, aw_fire, w_fire, b_fire, ar_fire, r_fire;
  int          aw_wait, w_wait, ar_wait, b_wait, r_wait;

  bsg_dmi_axil_master #(
    .base_addr_p (base_lp),
    .timeout_p   (timeout_lp)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .dmi_req_valid_i  (req_valid),
    .dmi_req_ready_o  (req_ready),
    .dmi_req_addr_i   (req_addr),
    .dmi_req_op_i     (req_op),
    .dmi_req_data_i   (req_data),
    .dmi_resp_valid_o (resp_valid),
    .dmi_resp_ready_i (resp_ready),
    .dmi_resp_data_o  (resp_data),
    .dmi_resp_resp_o  (resp_resp),
    .m_axil_awaddr    (awaddr),
    .m_axil_awprot    (awprot),
    .m_axil_awvalid   (awvalid),
    .m_axil_awready   (awready),
    .m_axil_wdata     (wdata),
    .m_axil_wstrb     (wstrb),
    .m_axil_wvalid    (wvalid),
    .m_axil_wready    (wready),
    .m_axil_bresp     (bresp),
    .m_axil_bvalid    (bvalid),
    .m_axil_bready    (bready),
    .m_axil_araddr    (araddr),
    .m_axil_arprot    (arprot),
    .m_axil_arvalid   (arvalid),
    .m_axil_arready   (arready),
    .m_axil_rdata     (rdata),
    .m_axil_rresp     (rresp),
    .m_axil_rvalid    (rvalid),
    .m_axil_rready    (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reactive slave: runs 1 time unit after each rising edge, applies the handshakes
  // of the edge just passed, then sets this cycle's ready/valid outputs.
  always begin
    @(posedge clk); #1;
    if (!rst_n) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    end else begin
      if (aw_fire) begin aw_hs++; aw_got = 1; end
      if (w_fire)  begin w_hs++;  w_got  = 1; end
      if (ar_fire) begin ar_hs++; ar_got = 1; end
      if (b_fire)  begin b_hs++; bvalid = 0; aw_got = 0; w_got = 0; b_wait = 0; end
      if (r_fire)  begin r_hs++; rvalid = 0; ar_got = 0; r_wait = 0; end
      if (awvalid || wvalid || arvalid) valid_seen++;
      if (awvalid) begin awready = (aw_wait >= aw_lat); if (!awready) aw_wait++; end
      else begin awready = 0; aw_wait = 0; end
      if (wvalid) begin wready = (w_wait >= w_lat); if (!wready) w_wait++; end
      else begin wready = 0; w_wait = 0; end
      if (arvalid) begin arready = (ar_wait >= ar_lat); if (!arready) ar_wait++; end
      else begin arready = 0; ar_wait = 0; end
      if (aw_got && w_got && !bvalid && !b_never) begin
        if (b_wait >= b_lat) begin bvalid = 1; bresp = bresp_cfg; end
        else b_wait++;
      end
      if (ar_got && !rvalid && !r_never) begin
        if (r_wait >= r_lat) begin rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg; end
        else r_wait++;
      end
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      ar_fire = arvalid && arready;
      b_fire  = bvalid && bready;
      r_fire  = rvalid && rready;
      if (aw_fire) awaddr_cap = awaddr;
      if (w_fire)  wdata_cap  = wdata;
      if (ar_fire) araddr_cap = araddr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

  task automatic slave_defaults();
    aw_lat = 0; w_lat = 0; ar_lat = 0; b_lat = 0; r_lat = 0;
    b_never = 0; r_never = 0;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; rdata_cfg = 32'h0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept, c0 = accept cycle.
  task automatic do_accept(input logic [6:0] a, input logic [1:0] op,
                           input logic [31:0] d, output int c0);
    int n = 0;
    req_valid = 1; req_addr = a; req_op = op; req_data = d;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, want 1", req_ready, n);
    end
    c0 = cyc;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_resp(input int max, output int c);
    int n = 0;
    while (!resp_valid && n < max) begin @(posedge clk); #1; n++; end
    total++;
    if (!resp_valid) begin
      bad++;
      $display("FAIL resp_timeout: resp_valid=%b after %0d cycles, want 1", resp_valid, n);
    end
    c = cyc;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b want=0", resp_valid); end
    total++; if ({awvalid, wvalid, arvalid} !== 3'b000) begin bad++; $display("FAIL rst_axi_valids got=%b want=000", {awvalid, wvalid, arvalid}); end
    total++; if ({bready, rready} !== 2'b00) begin bad++; $display("FAIL rst_readies got=%b want=00", {bready, rready}); end
    total++; if (resp_data !== 32'h0 || resp_resp !== 2'd0) begin bad++; $display("FAIL rst_resp_fields got=%h/%0d want=0/0", resp_data, resp_resp); end
    total++; if (awprot !== 3'd0 || arprot !== 3'd0 || wstrb !== 4'hf) begin bad++; $display("FAIL rst_const got=%0d/%0d/%h want=0/0/f", awprot, arprot, wstrb); end
    #2 rst_n = 1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_write();
    int c0, c, aw0, w0;
    aw0 = aw_hs; w0 = w_hs;
    do_accept(7'h10, 2'd2, 32'h1, c0);
    total++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin bad++; $display("FAIL wr_valids_c1 got=%b%b want=11", awvalid, wvalid); end
    total++; if (awaddr !== 32'h140) begin bad++; $display("FAIL wr_awaddr got=%h want=00000140", awaddr); end
    total++; if (wdata !== 32'h1 || wstrb !== 4'hf) begin bad++; $display("FAIL wr_wdata got=%h/%h want=00000001/f", wdata, wstrb); end
    wait_resp(20, c);
    total++; if (c - c0 !== 3) begin bad++; $display("FAIL wr_latency got=%0d want=3", c - c0); end
    total++; if (resp_resp !== 2'd0 || resp_data !== 32'h0) begin bad++; $display("FAIL wr_status got=%0d/%h want=0/0", resp_resp, resp_data); end
    @(posedge clk); #1;
    total++; if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin bad++; $display("FAIL wr_hs_count got=%0d/%0d want=1/1", aw_hs - aw0, w_hs - w0); end
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL wr_back_idle got=%b/%b want=0/1", resp_valid, req_ready); end
  endtask

  task automatic test_read();
    int c0, c;
    rdata_cfg = 32'h0003_0382;
    do_accept(7'h11, 2'd1, 32'hdead_beef, c0);
    wait_resp(20, c);
    total++; if (c - c0 !== 3) begin bad++; $display("FAIL rd_latency got=%0d want=3", c - c0); end
    total++; if (araddr_cap !== 32'h144) begin bad++; $display("FAIL rd_araddr got=%h want=00000144", araddr_cap); end
    total++; if (resp_data !== 32'h0003_0382 || resp_resp !== 2'd0) begin bad++; $display("FAIL rd_resp got=%h/%0d want=00030382/0", resp_data, resp_resp); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_skew();
    int c0, c, aw0, w0;
    aw0 = aw_hs; w0 = w_hs;
    aw_lat = 3;
    do_accept(7'h05, 2'd2, 32'hcafe_f00d, c0);
    @(posedge clk); #1;
    total++; if (awvalid !== 1'b1 || wvalid !== 1'b0) begin bad++; $display("FAIL skew_w_dropped got=%b%b want=10", awvalid, wvalid); end
    wait_resp(30, c);
    total++; if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin bad++; $display("FAIL skew_hs_count got=%0d/%0d want=1/1", aw_hs - aw0, w_hs - w0); end
    total++; if (awaddr_cap !== 32'h114 || wdata_cap !== 32'hcafe_f00d) begin bad++; $display("FAIL skew_payload got=%h/%h want=00000114/cafef00d", awaddr_cap, wdata_cap); end
    total++; if (resp_resp !== 2'd0) begin bad++; $display("FAIL skew_status got=%0d want=0", resp_resp); end
    @(posedge clk); #1;
    slave_defaults();
  endtask

  task automatic test_bresp_err();
    int c0, c;
    bresp_cfg = 2'b10;
    do_accept(7'h04, 2'd2, 32'h5, c0);
    wait_resp(20, c);
    total++; if (resp_resp !== 2'd2 || resp_data !== 32'h0) begin bad++; $display("FAIL bresp_err got=%0d/%h want=2/0", resp_resp, resp_data); end
    @(posedge clk); #1;
    slave_defaults();
  endtask

  task automatic test_nop_rsvd();
    int c0, c, v0;
    v0 = valid_seen;
    do_accept(7'h01, 2'd0, 32'h0, c0);
    wait_resp(10, c);
    total++; if (c - c0 !== 1) begin bad++; $display("FAIL nop_latency got=%0d want=1", c - c0); end
    total++; if (resp_resp !== 2'd0 || resp_data !== 32'h0) begin bad++; $display("FAIL nop_status got=%0d/%h want=0/0", resp_resp, resp_data); end
    @(posedge clk); #1;
    do_accept(7'h02, 2'd3, 32'h1234, c0);
    wait_resp(10, c);
    total++; if (resp_resp !== 2'd2 || resp_data !== 32'h0) begin bad++; $display("FAIL rsvd_status got=%0d/%h want=2/0", resp_resp, resp_data); end
    @(posedge clk); #1;
    total++; if (valid_seen !== v0) begin bad++; $display("FAIL nop_rsvd_axi_activity got=%0d want=%0d", valid_seen, v0); end
  endtask

  task automatic test_resp_hold();
    int c0, c, ar0;
    logic [31:0] d0;
    logic [1:0]  s0;
    rdata_cfg = 32'ha5a5_0001;
    resp_ready = 0;
    do_accept(7'h22, 2'd1, 32'h0, c0);
    wait_resp(20, c);
    d0 = resp_data; s0 = resp_resp;
    total++; if (d0 !== 32'ha5a5_0001) begin bad++; $display("FAIL hold_data got=%h want=a5a50001", d0); end
    ar0 = ar_hs;
    req_valid = 1; req_addr = 7'h23; req_op = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (resp_valid !== 1'b1 || resp_data !== d0 || resp_resp !== s0 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable cyc%0d got=%b/%h/%0d/%b want=1/%h/%0d/0", i, resp_valid, resp_data, resp_resp, req_ready, d0, s0);
      end
    end
    total++; if (ar_hs !== ar0 || arvalid !== 1'b0) begin bad++; $display("FAIL hold_no_accept got=%0d/%b want=%0d/0", ar_hs, arvalid, ar0); end
    req_valid = 0;
    resp_ready = 1;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL hold_release got=%b/%b want=0/1", resp_valid, req_ready); end
  endtask

  task automatic test_timeout();
    int c0, c, r0, n;
    r_never = 1;
    r0 = r_hs;
    do_accept(7'h11, 2'd1, 32'h0, c0);
    wait_resp(40, c);
    total++; if (c - c0 < timeout_lp || c - c0 > timeout_lp + 3) begin bad++; $display("FAIL to_latency got=%0d want=%0d..%0d", c - c0, timeout_lp, timeout_lp + 3); end
    total++; if (resp_resp !== 2'd2 || resp_data !== 32'h0) begin bad++; $display("FAIL to_status got=%0d/%h want=2/0", resp_resp, resp_data); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (req_ready !== 1'b0 || rready !== 1'b1) begin
        bad++;
        $display("FAIL orphan_hold cyc%0d got=%b/%b want=0/1", i, req_ready, rready);
      end
    end
    r_never = 0;
    n = 0;
    while (!req_ready && n < 10) begin @(posedge clk); #1; n++; end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL orphan_exit got=%b want=1", req_ready); end
    total++; if (r_hs - r0 !== 1) begin bad++; $display("FAIL orphan_absorb got=%0d want=1", r_hs - r0); end
    rdata_cfg = 32'h0000_0077;
    do_accept(7'h12, 2'd1, 32'h0, c0);
    wait_resp(20, c);
    total++; if (resp_resp !== 2'd0 || resp_data !== 32'h77) begin bad++; $display("FAIL to_recover got=%0d/%h want=0/00000077", resp_resp, resp_data); end
    @(posedge clk); #1;
    slave_defaults();
  endtask

  task automatic test_reset_in_wb();
    int c0, v;
    b_never = 1;
    do_accept(7'h30, 2'd2, 32'h99, c0);
    @(posedge clk); #1;
    total++; if (bready !== 1'b1 || awvalid !== 1'b0 || wvalid !== 1'b0) begin bad++; $display("FAIL wb_entered got=%b%b%b want=100", bready, awvalid, wvalid); end
    #2 rst_n = 0;
    #1;
    total++; if ({awvalid, wvalid, arvalid, bready, rready, resp_valid, req_ready} !== 7'b0) begin
      bad++; $display("FAIL wb_reset_async got=%b want=0000000", {awvalid, wvalid, arvalid, bready, rready, resp_valid, req_ready});
    end
    @(posedge clk); #2;
    rst_n = 1;
    b_never = 0;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wb_reset_idle got=%b want=1", req_ready); end
    v = 0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) v++;
      @(posedge clk); #1;
    end
    total++; if (v !== 0) begin bad++; $display("FAIL wb_reset_no_resp got=%0d want=0", v); end
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_addr = '0; req_op = '0; req_data = '0; resp_ready = 1;
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; valid_seen = 0;
    awaddr_cap = '0; wdata_cap = '0; araddr_cap = '0;
    slave_defaults();
    test_reset();
    test_write();
    test_read();
    test_write_skew();
    test_bresp_err();
    test_nop_rsvd();
    test_resp_hold();
    test_timeout();
    test_reset_in_wb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
